// File: rtl/id_hazard_forward_unit.sv
// id_hazard_forward_unit
// ID-stage hazard detection and operand forwarding control for the 5-stage
// ARM pipeline. Shadows dest/we/load of the instructions in EX, MEM and WB
// and produces per-operand forward selects (00 RF, 01 EX, 10 MEM, 11 WB)
// plus the load-use stall.
// Optional feature macro: HAZ_STATS_EN adds a saturating 16-bit stall counter
// on the stall_count port.
module id_hazard_forward_unit #(
    parameter int REG_W  = 4,
    parameter int PC_REG = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src_a,
    input  logic [REG_W-1:0] id_src_b,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_dest_we,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             pipe_hold,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic             stall
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0]      stall_count
`endif
);

    localparam logic [REG_W-1:0] LP_PC_IDX = REG_W'(PC_REG);

    // Tracking registers for the three downstream stages
    logic             r_ex_valid,  r_mem_valid,  r_wb_valid;
    logic [REG_W-1:0] r_ex_dest,   r_mem_dest,   r_wb_dest;
    logic             r_ex_we,     r_mem_we,     r_wb_we;
    logic             r_ex_load,   r_mem_load;

    // A source is a forwarding candidate only if ID is real, the operand is
    // actually read, and it is not the PC (PC is never forwarded).
    logic w_src_ok_a, w_src_ok_b;
    logic w_ex_a,  w_ex_b;
    logic w_mem_a, w_mem_b;
    logic w_wb_a,  w_wb_b;
    logic w_stall;

    function automatic logic f_match(
        input logic             valid,
        input logic             we,
        input logic [REG_W-1:0] dest,
        input logic [REG_W-1:0] src,
        input logic             src_ok
    );
        return valid & we & (dest == src) & src_ok;
    endfunction

    assign w_src_ok_a = id_valid & id_use_a & (id_src_a != LP_PC_IDX);
    assign w_src_ok_b = id_valid & id_use_b & (id_src_b != LP_PC_IDX);

    assign w_ex_a  = f_match(r_ex_valid,  r_ex_we,  r_ex_dest,  id_src_a, w_src_ok_a);
    assign w_ex_b  = f_match(r_ex_valid,  r_ex_we,  r_ex_dest,  id_src_b, w_src_ok_b);
    assign w_mem_a = f_match(r_mem_valid, r_mem_we, r_mem_dest, id_src_a, w_src_ok_a);
    assign w_mem_b = f_match(r_mem_valid, r_mem_we, r_mem_dest, id_src_b, w_src_ok_b);
    assign w_wb_a  = f_match(r_wb_valid,  r_wb_we,  r_wb_dest,  id_src_a, w_src_ok_a);
    assign w_wb_b  = f_match(r_wb_valid,  r_wb_we,  r_wb_dest,  id_src_b, w_src_ok_b);

    // Load-use: a load in EX cannot forward yet; flush overrides the stall.
    assign w_stall = id_valid & ~flush & r_ex_valid & r_ex_load & (w_ex_a | w_ex_b);
    assign stall   = w_stall;

    // Forward select, youngest producer first; a load in EX is skipped so
    // the select never points at data that does not exist yet.
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs (no latch).
        fwd_sel_a = 2'b00;
        fwd_sel_b = 2'b00;
        if (w_ex_a && !r_ex_load) fwd_sel_a = 2'b01;
        else if (w_mem_a)         fwd_sel_a = 2'b10;
        else if (w_wb_a)          fwd_sel_a = 2'b11;
        if (w_ex_b && !r_ex_load) fwd_sel_b = 2'b01;
        else if (w_mem_b)         fwd_sel_b = 2'b10;
        else if (w_wb_b)          fwd_sel_b = 2'b11;
    end

    // Stage shift: WB<-MEM<-EX<-ID, with a bubble into EX on stall or flush
    always_ff @(posedge clk) begin
        // NOTE: the dest/we/load fields are reset too, not just valid, so the
        // tracking state is fully defined after reset.
        if (reset) begin
            r_ex_valid  <= 1'b0;
            r_ex_dest   <= '0;
            r_ex_we     <= 1'b0;
            r_ex_load   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_dest  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_load  <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_dest   <= '0;
            r_wb_we     <= 1'b0;
        end else if (!pipe_hold) begin
            // NOTE: non-blocking so each stage captures the pre-edge value of
            // the stage in front of it.
            r_wb_valid  <= r_mem_valid;
            r_wb_dest   <= r_mem_dest;
            r_wb_we     <= r_mem_we;
            r_mem_valid <= r_ex_valid;
            r_mem_dest  <= r_ex_dest;
            r_mem_we    <= r_ex_we;
            r_mem_load  <= r_ex_load;
            r_ex_valid  <= id_valid & ~w_stall & ~flush;
            r_ex_dest   <= id_dest;
            r_ex_we     <= id_dest_we;
            r_ex_load   <= id_is_load;
        end
    end

`ifdef HAZ_STATS_EN
    logic [15:0] r_stall_count;

    // Saturating count of advancing load-use stall cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 16'h0000;
        end else if (w_stall && !pipe_hold && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'h0001;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_id_hazard_forward_unit.sv
// Self-checking bench for id_hazard_forward_unit. A queue-based reference
// model (youngest instruction at index 0) is compared on every falling edge;
// directed steps also carry hand-computed literal expectations.
module tb_id_hazard_forward_unit;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [3:0] id_src_a, id_src_b;
    logic       id_use_a, id_use_b;
    logic [3:0] id_dest;
    logic       id_dest_we;
    logic       id_is_load;
    logic       flush;
    logic       pipe_hold;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic       stall;
`ifdef HAZ_STATS_EN
    logic [15:0] stall_count;
`endif

    id_hazard_forward_unit #(.REG_W(4), .PC_REG(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_src_a   (id_src_a),
        .id_src_b   (id_src_b),
        .id_use_a   (id_use_a),
        .id_use_b   (id_use_b),
        .id_dest    (id_dest),
        .id_dest_we (id_dest_we),
        .id_is_load (id_is_load),
        .flush      (flush),
        .pipe_hold  (pipe_hold),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .stall      (stall)
`ifdef HAZ_STATS_EN
        ,
        .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        bit       valid;
        bit [3:0] dest;
        bit       we;
        bit       load;
    } instr_t;

    instr_t      hist[$];      // hist[0] = EX, [1] = MEM, [2] = WB
    bit [15:0]   m_cnt    = 0;
    bit          model_ok = 0;

    // Age of the youngest usable producer (1 EX, 2 MEM, 3 WB), 0 = register file
    function automatic bit [1:0] m_fwd(input bit [3:0] src, input bit use_s);
        if (!id_valid || !use_s || src == 4'd15) return 2'd0;
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i].valid && hist[i].we && hist[i].dest == src) begin
                if (!(i == 0 && hist[i].load)) return 2'(i + 1);
            end
        end
        return 2'd0;
    endfunction

    function automatic bit m_stall();
        bit ra, rb;
        if (!id_valid || flush || hist.size() == 0) return 1'b0;
        if (!hist[0].valid || !hist[0].load || !hist[0].we) return 1'b0;
        ra = id_use_a && id_src_a != 4'd15 && id_src_a == hist[0].dest;
        rb = id_use_b && id_src_b != 4'd15 && id_src_b == hist[0].dest;
        return ra || rb;
    endfunction

    always @(posedge clk) begin
        bit     ms;
        instr_t e;
        ms = m_stall();
        if (reset) begin
            hist.delete();
            m_cnt    = 0;
            model_ok = 1;
        end else if (!pipe_hold) begin
            if (ms && m_cnt != 16'hFFFF) m_cnt++;
            e.valid = id_valid && !ms && !flush;
            e.dest  = id_dest;
            e.we    = id_dest_we;
            e.load  = id_is_load;
            hist.push_front(e);
            if (hist.size() > 3) void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("cmp_fwd_a", {14'd0, fwd_sel_a}, {14'd0, m_fwd(id_src_a, id_use_a)});
            check("cmp_fwd_b", {14'd0, fwd_sel_b}, {14'd0, m_fwd(id_src_b, id_use_b)});
            check("cmp_stall", {15'd0, stall},     {15'd0, m_stall()});
`ifdef HAZ_STATS_EN
            check("cmp_count", stall_count, m_cnt);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input bit [3:0] sa, input bit ua,
                         input bit [3:0] sb, input bit ub, input bit [3:0] d,
                         input bit we, input bit ld, input bit fl, input bit ph);
        id_valid = v;  id_src_a = sa; id_use_a = ua; id_src_b = sb; id_use_b = ub;
        id_dest = d;   id_dest_we = we; id_is_load = ld; flush = fl; pipe_hold = ph;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // writer of rd (ALU op or load), reads nothing
    task automatic writer(input bit [3:0] rd, input bit ld);
        drive(1, 0, 0, 0, 0, rd, 1, ld, 0, 0);
    endtask

    // reader of rs on both operands, writes nothing
    task automatic reader(input bit [3:0] rs, input bit fl, input bit ph);
        drive(1, rs, 1, rs, 1, 0, 0, 0, fl, ph);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;

        // Reset state and a read with no prior writers
        drive(1, 4'd3, 1, 4'd0, 0, 0, 0, 0, 0, 0);
        settle();
        check("reset_fwd_a", {14'd0, fwd_sel_a}, 16'd0);
        check("reset_fwd_b", {14'd0, fwd_sel_b}, 16'd0);
        check("reset_stall", {15'd0, stall}, 16'd0);
        tick();

        // ADD r1, then readers at distance 1,2,3,4
        writer(4'd1, 0); tick();
        reader(4'd1, 0, 0); settle();
        check("dist1_a", {14'd0, fwd_sel_a}, 16'd1);
        check("dist1_b", {14'd0, fwd_sel_b}, 16'd1);
        tick(); settle();
        check("dist2_a", {14'd0, fwd_sel_a}, 16'd2);
        tick(); settle();
        check("dist3_a", {14'd0, fwd_sel_a}, 16'd3);
        tick(); settle();
        check("dist4_a", {14'd0, fwd_sel_a}, 16'd0);
        tick();

        // ADD r2, SUB r2, reader: youngest wins
        writer(4'd2, 0); tick();
        writer(4'd2, 0); tick();
        reader(4'd2, 0, 0); settle();
        check("youngest_a", {14'd0, fwd_sel_a}, 16'd1);
        tick();

        // LDR r4, dependent reader: one stall, then MEM forward
        idle(); tick();
`ifdef HAZ_STATS_EN
        settle();
        check("count_pre", stall_count, 16'd0);
`endif
        writer(4'd4, 1); tick();
        reader(4'd4, 0, 0); settle();
        check("ldu_stall", {15'd0, stall}, 16'd1);
        tick(); settle();
        check("ldu_after_stall", {15'd0, stall}, 16'd0);
        check("ldu_after_fwd", {14'd0, fwd_sel_a}, 16'd2);
`ifdef HAZ_STATS_EN
        check("count_one", stall_count, 16'd1);
`endif
        tick();

        // LDR r4, then reader that also writes r4, flushed: no stall, bubble
        writer(4'd4, 1); tick();
        drive(1, 4'd4, 1, 4'd4, 1, 4'd4, 1, 0, 1, 0); settle();
        check("flush_stall", {15'd0, stall}, 16'd0);
        tick();
        reader(4'd4, 0, 0); settle();
        check("flush_bubble_fwd", {14'd0, fwd_sel_a}, 16'd2);
        tick();

        // MOV r15, reader of r15: never forwarded
        writer(4'd15, 0); tick();
        reader(4'd15, 0, 0); settle();
        check("pc_fwd_a", {14'd0, fwd_sel_a}, 16'd0);
        check("pc_fwd_b", {14'd0, fwd_sel_b}, 16'd0);
        tick();

        // ADD r5, then hold for three edges
        writer(4'd5, 0); tick();
        reader(4'd5, 0, 1); settle();
        check("hold0", {14'd0, fwd_sel_a}, 16'd1);
        tick(); settle();
        check("hold1", {14'd0, fwd_sel_a}, 16'd1);
        tick(); settle();
        check("hold2", {14'd0, fwd_sel_a}, 16'd1);
        tick();
        reader(4'd5, 0, 0); settle();
        check("hold3", {14'd0, fwd_sel_a}, 16'd1);
        tick(); settle();
        check("release", {14'd0, fwd_sel_a}, 16'd2);
        tick();

        // Reset during a stall
        writer(4'd6, 1); tick();
        reader(4'd6, 0, 0); settle();
        check("rst_stall_pre", {15'd0, stall}, 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("rst_stall_post", {15'd0, stall}, 16'd0);
        check("rst_fwd_post", {14'd0, fwd_sel_a}, 16'd0);
        idle(); tick();

`ifdef HAZ_STATS_EN
        // Saturation: preload to FFFE, then two more stalls
        force dut.r_stall_count = 16'hFFFE;
        m_cnt = 16'hFFFE;
        tick();
        release dut.r_stall_count;
        writer(4'd7, 1); tick();
        reader(4'd7, 0, 0); tick(); settle();
        check("count_ffff", stall_count, 16'hFFFF);
        writer(4'd7, 1); tick();
        reader(4'd7, 0, 0); settle();
        check("sat_stall", {15'd0, stall}, 16'd1);
        tick(); settle();
        check("count_sat", stall_count, 16'hFFFF);
`endif

        idle();
        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
